data_main_memory: RTL and testbench
===================================

Name: data_main_memory

Overview:
- Backing main memory that sits directly downstream of the data-cache controller.
- Services block refills on read misses and single-word write-through stores.
- Models fixed access latency and returns a one-cycle `ready` pulse that closes the controller's reading/writing states.
- Word-addressed, 1024 x 32-bit. Refill returns a whole 4-word line.

Parameters:
- ADDR_WIDTH, 10, word address width (tag 3 + index 5 + offset 2).
- DATA_WIDTH, 32, word width.
- WORDS_PER_BLOCK, 4, words per cache line. Must be a power of two.
- LATENCY, 4, clk cycles from request acceptance to `ready` pulse. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- read  in  1  refill request level from controller; held until `ready` is seen.
- write  in  1  write-through request level from controller; held until `ready` is seen.
- addr  in  ADDR_WIDTH  word address, stable while request is held.
- wdata  in  DATA_WIDTH  store data, stable while `write` is held.
- ready  out  1  one-cycle completion pulse.
- rdata_block  out  DATA_WIDTH*WORDS_PER_BLOCK  refill line; word k at bits [32k+31:32k].

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, ready=0, rdata_block=0, every memory word=0. Asserting rst mid-operation aborts it: a pending write is discarded and no `ready` is produced.
- State machine: IDLE, BUSY, DONE.
- IDLE
  - If write=1, latch op=WR, addr and wdata; counter=LATENCY-1; go to BUSY.
  - Else if read=1, latch op=RD and addr; counter=LATENCY-1; go to BUSY.
  - Write has priority if both are asserted (illegal from the controller, but defined).
- BUSY, counter!=0: decrement counter; stay in BUSY.
- BUSY, counter==0:
  - Perform the op at this posedge: RD loads rdata_block from words {addr[9:2],2'b00} .. {addr[9:2],2'b11}; WR writes mem[addr]=wdata.
  - Set ready=1 for exactly one cycle; go to DONE.
- LATENCY=1 means ready rises at the posedge after acceptance. Generally, ready is high during cycle LATENCY after the acceptance edge.
- DONE: ready=0. Stay in DONE while read|write=1. Return to IDLE when both are low. This prevents re-triggering, because the controller drops its request at the negedge following `ready`.
- rdata_block holds its last value until the next RD completion. WR does not change rdata_block.
- Request inputs are ignored in BUSY (latched copies are used). Changes to addr/wdata mid-op have no effect.
- Block address uses addr[ADDR_WIDTH-1:2]. The offset bits are ignored for RD and used for WR.
- Write-after-read coherence: an RD issued after a completed WR to the same line returns the new word.
- ready is registered on posedge. The controller samples it on the following negedge (half-cycle margin).

Decomposition:
- Shared package:
  - state encoding localparams (IDLE=2'b00, BUSY=2'b01, DONE=2'b10)
  - op encoding (RD=0, WR=1)
  - the ADDR/DATA/WORDS_PER_BLOCK constants shared with the cache data array and the cache controller.
- One natural sub-module, `mem_latency_counter`: loadable down-counter with load, enable and zero flag, async reset. The storage array and FSM stay in the top module.

Test Plan:
- Reset then idle: rst pulse with read=write=0 for 20 cycles -> ready never asserts, rdata_block=0.
- Write-through: write=1, addr=10'h05A, wdata=32'hDEADBEEF, LATENCY=4 -> ready high exactly one cycle, 4 cycles after acceptance; the controller drops write; FSM returns to IDLE; mem[0x05A]=DEADBEEF.
- Refill after write: preload words 0x058..0x05B with 1,2,3,4 via writes; read=1, addr=10'h059 -> rdata_block=128'h00000004_00000003_00000002_00000001, one ready pulse, the offset ignored.
- Held request: keep read=1 for 3 cycles after ready -> no second ready; FSM stays in DONE until read falls, then IDLE.
- Simultaneous read & write at addr=0x010, wdata=0x55 -> treated as WR; mem[0x010]=0x55; rdata_block unchanged.
- Reset mid-op: start WR to 0x1FF, assert rst in cycle 2 -> no ready; mem[0x1FF]=0; the next RD of that line returns all zeros.

Source files
------------

// File: rtl/data_main_memory_pkg.sv
// Shared constants and encodings for the data-cache backing memory,
// also used by the cache data array and the cache controller.
package data_main_memory_pkg;

  localparam int unsigned MEM_ADDR_WIDTH      = 10;
  localparam int unsigned MEM_DATA_WIDTH      = 32;
  localparam int unsigned MEM_WORDS_PER_BLOCK = 4;
  localparam int unsigned MEM_LATENCY         = 4;
  localparam int unsigned MEM_CNT_WIDTH       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/data_main_memory_latency_counter.sv
// Loadable down-counter with a registered zero flag; times the memory access.
module mem_latency_counter
  import data_main_memory_pkg::*;
#(
  parameter int unsigned WIDTH = MEM_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             zero_q, zero_d;

  // Zero flag is computed alongside the count so it is available as a flop output.
  always_comb begin
    count_d = count_q;
    zero_d  = zero_q;
    if (load_i) begin
      count_d = load_val_i;
      zero_d  = (load_val_i == '0);
    end else if (en_i && !zero_q) begin
      count_d = count_q - WIDTH'(1);
      zero_d  = (count_q == WIDTH'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/data_main_memory.sv
// Word-addressed backing memory for the data cache: fixed-latency line refills
// and single-word write-through stores, each closed by a one-cycle ready pulse.
module data_main_memory
  import data_main_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = MEM_DATA_WIDTH,
  parameter int unsigned WORDS_PER_BLOCK = MEM_WORDS_PER_BLOCK,
  parameter int unsigned LATENCY         = MEM_LATENCY
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  read,
  input  logic                                  write,
  input  logic [ADDR_WIDTH-1:0]                 addr,
  input  logic [DATA_WIDTH-1:0]                 wdata,
  output logic                                  ready,
  output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] rdata_block
);

  localparam int unsigned DEPTH        = 1 << ADDR_WIDTH;
  localparam int unsigned OFFSET_WIDTH = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned BLOCK_WIDTH  = DATA_WIDTH * WORDS_PER_BLOCK;

  state_t                  state_q, state_d;
  op_t                     op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    ready_q, ready_d;
  logic [BLOCK_WIDTH-1:0]  rdata_block_q, rdata_block_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic accept;
  logic cnt_en;
  logic cnt_zero;
  logic fire;
  logic wr_fire;

  mem_latency_counter #(
    .WIDTH(MEM_CNT_WIDTH)
  ) u_latency_counter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .en_i      (cnt_en),
    .load_val_i(MEM_CNT_WIDTH'(LATENCY - 1)),
    .zero_o    (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; DONE waits for the request to drop so it cannot re-trigger
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (read || write) state_d = BUSY;
      BUSY:    if (cnt_zero) state_d = DONE;
      DONE:    if (!read && !write) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    accept  = 1'b0;
    cnt_en  = 1'b0;
    fire    = 1'b0;
    wr_fire = 1'b0;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          accept  = 1'b1;
          op_d    = write ? OP_WR : OP_RD;
          addr_d  = addr;
          wdata_d = wdata;
        end
      end
      BUSY: begin
        cnt_en  = !cnt_zero;
        fire    = cnt_zero;
        wr_fire = cnt_zero && (op_q == OP_WR);
        ready_d = cnt_zero;
      end
      default: ;
    endcase
  end

  // Refill gathers the whole aligned line; the offset bits of the address are dropped
  always_comb begin
    rdata_block_d = rdata_block_q;
    if (fire && (op_q == OP_RD)) begin
      for (int k = 0; k < int'(WORDS_PER_BLOCK); k++) begin
        rdata_block_d[k*DATA_WIDTH +: DATA_WIDTH] =
          mem_q[{addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'(k)}];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q          <= OP_RD;
      addr_q        <= '0;
      wdata_q       <= '0;
      ready_q       <= 1'b0;
      rdata_block_q <= '0;
    end else begin
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      ready_q       <= ready_d;
      rdata_block_q <= rdata_block_d;
    end
  end

  // Storage array; cleared on reset so an aborted store leaves no trace
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_fire) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign ready       = ready_q;
  assign rdata_block = rdata_block_q;

endmodule

// File: tb/tb_data_main_memory.sv
// Directed self-checking bench for data_main_memory (LATENCY=4 and LATENCY=1 instances).
module tb_data_main_memory;

  logic         clk;
  logic         rst;
  logic         read, write;
  logic [9:0]   addr;
  logic [31:0]  wdata;
  logic         ready;
  logic [127:0] rdata_block;

  logic         read1, write1;
  logic [9:0]   addr1;
  logic [31:0]  wdata1;
  logic         ready1;
  logic [127:0] rdata_block1;

  int errors = 0;
  int checks = 0;

  data_main_memory #(.LATENCY(4)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata_block(rdata_block)
  );

  data_main_memory #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .read(read1), .write(write1), .addr(addr1),
    .wdata(wdata1), .ready(ready1), .rdata_block(rdata_block1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request on the LATENCY=4 instance; lat counts negedges from drive to ready
  // (acceptance posedge + LATENCY cycles => LATENCY+1), extra is ready one cycle later.
  task automatic do_req(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [31:0] d, output int lat, output logic extra);
    @(negedge clk);
    read = rd; write = wr; addr = a; wdata = d;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        addr  = ~a;
        wdata = ~d;
      end
      if (ready === 1'b1) begin
        lat = i;
        break;
      end
    end
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    extra = ready;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1; read = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    read1 = 1'b0; write1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || rdata_block !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rdata=%h expected 0/0", ready, rdata_block);
    end
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready === 1'b1) cnt++;
    end
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL idle_no_ready: ready pulses=%0d expected 0", cnt);
    end
    checks++;
    if (rdata_block !== 128'h0) begin
      errors++;
      $display("FAIL idle_rdata: got %h expected 0", rdata_block);
    end
  endtask

  task automatic test_write_through();
    int lat; logic extra;
    do_req(1'b0, 1'b1, 10'h05A, 32'hDEADBEEF, lat, extra);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL wr_latency: got %0d expected 5", lat);
    end
    checks++;
    if (extra !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse_width: ready=%b expected 0", extra);
    end
    checks++;
    if (rdata_block !== 128'h0) begin
      errors++;
      $display("FAIL wr_rdata_untouched: got %h expected 0", rdata_block);
    end
    do_req(1'b1, 1'b0, 10'h058, 32'h0, lat, extra);
    checks++;
    if (rdata_block !== 128'h00000000_DEADBEEF_00000000_00000000) begin
      errors++;
      $display("FAIL wr_readback: got %h expected 00000000deadbeef0000000000000000", rdata_block);
    end
  endtask

  task automatic test_refill();
    int lat; logic extra;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 1'b1, 10'h058 + 10'(i), 32'(i + 1), lat, extra);
    end
    do_req(1'b1, 1'b0, 10'h059, 32'h0, lat, extra);
    checks++;
    if (lat !== 5 || extra !== 1'b0) begin
      errors++;
      $display("FAIL rd_timing: lat=%0d extra=%b expected 5/0", lat, extra);
    end
    checks++;
    if (rdata_block !== 128'h00000004_00000003_00000002_00000001) begin
      errors++;
      $display("FAIL rd_refill: got %h expected 00000004000000030000000200000001", rdata_block);
    end
  endtask

  task automatic test_held_request();
    int lat; int cnt; logic bad_state;
    @(negedge clk);
    read = 1'b1; addr = 10'h05A;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL held_latency: got %0d expected 5", lat);
    end
    cnt = 0; bad_state = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready === 1'b1) cnt++;
      if (dut.state_q !== 2'b10) bad_state = 1'b1;
    end
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL held_no_retrigger: extra pulses=%0d expected 0", cnt);
    end
    checks++;
    if (bad_state !== 1'b0) begin
      errors++;
      $display("FAIL held_in_done: state left DONE=%b expected 0", bad_state);
    end
    read = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== 2'b00) begin
      errors++;
      $display("FAIL held_back_idle: state=%b expected 00", dut.state_q);
    end
    checks++;
    if (rdata_block !== 128'h00000004_00000003_00000002_00000001) begin
      errors++;
      $display("FAIL held_rdata: got %h expected 00000004000000030000000200000001", rdata_block);
    end
  endtask

  task automatic test_simultaneous();
    int lat; logic extra;
    do_req(1'b1, 1'b1, 10'h010, 32'h00000055, lat, extra);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL both_latency: got %0d expected 5", lat);
    end
    checks++;
    if (rdata_block !== 128'h00000004_00000003_00000002_00000001) begin
      errors++;
      $display("FAIL both_rdata_unchanged: got %h expected 00000004000000030000000200000001", rdata_block);
    end
    do_req(1'b1, 1'b0, 10'h012, 32'h0, lat, extra);
    checks++;
    if (rdata_block !== 128'h00000000_00000000_00000000_00000055) begin
      errors++;
      $display("FAIL both_as_write: got %h expected 00000000000000000000000000000055", rdata_block);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; int cnt; logic extra;
    @(negedge clk);
    write = 1'b1; addr = 10'h1FF; wdata = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    write = 1'b0;
    checks++;
    if (rdata_block !== 128'h0) begin
      errors++;
      $display("FAIL rst_mid_rdata: got %h expected 0", rdata_block);
    end
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready === 1'b1) cnt++;
    end
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL rst_mid_no_ready: pulses=%0d expected 0", cnt);
    end
    do_req(1'b1, 1'b0, 10'h1FC, 32'h0, lat, extra);
    checks++;
    if (lat !== 5 || rdata_block !== 128'h0) begin
      errors++;
      $display("FAIL rst_mid_discarded: lat=%0d rdata=%h expected 5/0", lat, rdata_block);
    end
    do_req(1'b1, 1'b0, 10'h058, 32'h0, lat, extra);
    checks++;
    if (rdata_block !== 128'h0) begin
      errors++;
      $display("FAIL rst_mem_cleared: got %h expected 0", rdata_block);
    end
  endtask

  task automatic test_latency_one();
    int lat;
    @(negedge clk);
    write1 = 1'b1; addr1 = 10'h003; wdata1 = 32'h12345678;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ready1 === 1'b1) begin
        lat = i;
        break;
      end
    end
    write1 = 1'b0;
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL lat1_write: got %0d expected 2", lat);
    end
    @(negedge clk);
    read1 = 1'b1; addr1 = 10'h000;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ready1 === 1'b1) begin
        lat = i;
        break;
      end
    end
    read1 = 1'b0;
    checks++;
    if (lat !== 2 || rdata_block1 !== 128'h12345678_00000000_00000000_00000000) begin
      errors++;
      $display("FAIL lat1_read: lat=%0d rdata=%h expected 2/12345678000000000000000000000000", lat, rdata_block1);
    end
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1_pulse_width: ready=%b expected 0", ready1);
    end
  endtask

  initial begin
    test_reset();
    test_write_through();
    test_refill();
    test_held_request();
    test_simultaneous();
    test_reset_mid_op();
    test_latency_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
